// File: rtl/alu_entry_ctrl.sv
// Operand-entry front end for the 4-bit board ALU. A debounced ENTER button steps
// a, b and mod into registers, then the ALU result is captured for display.
module alu_entry_ctrl #(
  parameter int DEB_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_sw,
  input  logic       i_btn,
  input  logic       i_clr,
  input  logic [3:0] i_res,
  input  logic       i_cout,
  input  logic       i_overflow,
  output logic [3:0] o_a,
  output logic [3:0] o_b,
  output logic [2:0] o_mod,
  output logic       o_valid,
  output logic [3:0] o_res_q,
  output logic [1:0] o_flags_q,
  output logic [2:0] o_state
);

  // state  | meaning
  // S_A    | waiting for operand a
  // S_B    | waiting for operand b
  // S_OP   | waiting for operation select
  // S_EXEC | ALU inputs complete, result captured at the closing edge
  // S_SHOW | result displayed; next press starts a new entry with a
  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  localparam logic [15:0] DEB_TC = 16'(DEB_CYCLES - 1);

  logic        s1_q, s1_d;
  logic        s2_q, s2_d;
  logic        stable_q, stable_d;
  logic        stable_dly_q, stable_dly_d;
  logic [15:0] cnt_q, cnt_d;
  logic        press_q, press_d;

  state_t      state_q, state_d;
  logic [3:0]  a_q, a_d;
  logic [3:0]  b_q, b_d;
  logic [2:0]  mod_q, mod_d;
  logic        valid_q, valid_d;
  logic [3:0]  res_q, res_d;
  logic [1:0]  flags_q, flags_d;

  // Debouncer: the counter only runs while the synchronized level disagrees with
  // the accepted level, so any bounce back restarts the qualification window.
  always_comb begin
    s1_d         = i_btn;
    s2_d         = s1_q;
    stable_d     = stable_q;
    cnt_d        = cnt_q;
    stable_dly_d = stable_q;
    press_d      = stable_q & ~stable_dly_q;
    if (s2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == DEB_TC) begin
      stable_d = s2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
      press_q      <= 1'b0;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      stable_q     <= stable_d;
      stable_dly_q <= stable_dly_d;
      cnt_q        <= cnt_d;
      press_q      <= press_d;
    end
  end

  // o_valid is registered alongside the move into S_EXEC, so it is high for
  // exactly the S_EXEC cycle; a press arriving in S_EXEC is ignored.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mod_d   = mod_q;
    valid_d = 1'b0;
    res_d   = res_q;
    flags_d = flags_q;
    if (i_clr) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      mod_d   = '0;
      res_d   = '0;
      flags_d = '0;
    end else begin
      unique case (state_q)
        S_A: begin
          if (press_q) begin
            a_d     = i_sw;
            state_d = S_B;
          end
        end
        S_B: begin
          if (press_q) begin
            b_d     = i_sw;
            state_d = S_OP;
          end
        end
        S_OP: begin
          if (press_q) begin
            mod_d   = i_sw[2:0];
            state_d = S_EXEC;
            valid_d = 1'b1;
          end
        end
        S_EXEC: begin
          res_d   = i_res;
          flags_d = {i_cout, i_overflow};
          state_d = S_SHOW;
        end
        S_SHOW: begin
          if (press_q) begin
            a_d     = i_sw;
            state_d = S_B;
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      mod_q   <= '0;
      valid_q <= 1'b0;
      res_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mod_q   <= mod_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      flags_q <= flags_d;
    end
  end

  assign o_a       = a_q;
  assign o_b       = b_q;
  assign o_mod     = mod_q;
  assign o_valid   = valid_q;
  assign o_res_q   = res_q;
  assign o_flags_q = flags_q;
  assign o_state   = state_q;

endmodule
